// File: rtl/track_pkg.sv
// ============================================================================
//  track_pkg
//  Shared types and display codes for the train-loop sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package track_pkg;

    localparam int N_SEC_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_MOVE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [3:0] PS_IDLE       = 4'h0;
    localparam logic [3:0] PS_DWELL_BASE = 4'h1;
    localparam logic [3:0] PS_MOVE_BASE  = 4'h8;
    localparam logic [3:0] PS_FAULT      = 4'hF;

    function automatic logic [3:0] ps_code(input state_t st, input logic [2:0] sec);
        logic [3:0] code;
        case (st)
            ST_DWELL: code = PS_DWELL_BASE + {1'b0, sec};
            ST_MOVE:  code = PS_MOVE_BASE + {1'b0, sec};
            ST_FAULT: code = PS_FAULT;
            default:  code = PS_IDLE;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_downcounter.sv
// ============================================================================
//  tick_downcounter
//  Loadable down-counter that decrements on tick and saturates at zero.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tick_downcounter #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/track_sequencer.sv
// ============================================================================
//  track_sequencer
//  Advances the train around the loop with station dwell and move watchdog.
//  Optional macro WATCHDOG_EN enables the MOVE timeout.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module track_sequencer
    import track_pkg::*;
#(
    parameter int N_SEC   = N_SEC_DEFAULT,
    parameter int DWELL_W = 15,
    parameter int TOUT_W  = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [N_SEC-1:0]   sensor,
    input  logic               start,
    input  logic               clear,
    input  logic [DWELL_W-1:0] dwell_time,
    input  logic [TOUT_W-1:0]  timeout,
    output logic [2:0]         section,
    output logic [3:0]         present_state,
    output logic               motor_en,
    output logic               fault,
    output logic               arrive
);

    localparam int C_CNT_W = (DWELL_W > TOUT_W) ? DWELL_W : TOUT_W;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_section;
    logic [2:0]         w_section_nxt;
    logic [N_SEC-1:0]   r_sensor_q;
    logic               r_armed;
    logic               w_armed_nxt;
    logic               w_arrive_nxt;
    logic               w_load;
    logic [C_CNT_W-1:0] w_load_val;
    logic               w_zero;

    logic [N_SEC-1:0]   w_rise;
    logic [2:0]         w_nxt;
    logic [N_SEC-1:0]   w_nxt_mask;
    logic               w_foreign;
    logic               w_expected;

`ifndef WATCHDOG_EN
    logic w_unused_timeout;
    assign w_unused_timeout = ^timeout;
`endif

    assign w_rise     = sensor & ~r_sensor_q;
    assign w_nxt      = (r_section == 3'(N_SEC - 1)) ? 3'd0 : r_section + 3'd1;
    assign w_nxt_mask = N_SEC'(1) << w_nxt;
    assign w_foreign  = |(w_rise & ~w_nxt_mask);
    assign w_expected = |(w_rise & w_nxt_mask);

    // Dwell and watchdog never run together, so one counter serves both.
    tick_downcounter #(
        .WIDTH (C_CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .load  (w_load),
        .value (w_load_val),
        .zero  (w_zero)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_section_nxt = r_section;
        w_armed_nxt   = r_armed;
        w_arrive_nxt  = 1'b0;
        w_load        = 1'b0;
        w_load_val    = '0;
        case (r_state)
            ST_IDLE: begin
                if (start && sensor[0]) begin
                    w_section_nxt = 3'd0;
                    w_load        = 1'b1;
                    w_load_val    = C_CNT_W'(dwell_time);
                    w_state_nxt   = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (w_zero) begin
                    w_state_nxt = ST_MOVE;
`ifdef WATCHDOG_EN
                    w_load      = 1'b1;
                    w_load_val  = C_CNT_W'(timeout);
                    w_armed_nxt = (timeout != '0);
`else
                    w_armed_nxt = 1'b0;
`endif
                end
            end
            ST_MOVE: begin
                // A foreign edge faults even when the expected edge arrives too.
                if (w_foreign) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_expected) begin
                    w_section_nxt = w_nxt;
                    w_arrive_nxt  = 1'b1;
                    w_load        = 1'b1;
                    w_load_val    = C_CNT_W'(dwell_time);
                    w_state_nxt   = ST_DWELL;
                end else if (r_armed && w_zero) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (clear) begin
                    w_section_nxt = 3'd0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_section_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_section     <= 3'd0;
            r_sensor_q    <= '1;
            r_armed       <= 1'b0;
            present_state <= PS_IDLE;
            motor_en      <= 1'b0;
            fault         <= 1'b0;
            arrive        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_section     <= w_section_nxt;
            r_sensor_q    <= sensor;
            r_armed       <= w_armed_nxt;
            present_state <= ps_code(w_state_nxt, w_section_nxt);
            motor_en      <= (w_state_nxt == ST_MOVE);
            fault         <= (w_state_nxt == ST_FAULT);
            arrive        <= w_arrive_nxt;
        end
    end

    assign section = r_section;

endmodule

`default_nettype wire

// File: tb/tb_track_sequencer.sv
// ============================================================================
//  tb_track_sequencer
//  Directed scenarios plus randomized traffic against a behavioural model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_track_sequencer;

    localparam int N = 6;
`ifdef WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_DWELL = 1;
    localparam int M_MOVE  = 2;
    localparam int M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [5:0]  sensor;
    logic        start;
    logic        clear;
    logic [14:0] dwell_time;
    logic [18:0] timeout;
    logic [2:0]  section;
    logic [3:0]  present_state;
    logic        motor_en;
    logic        fault;
    logic        arrive;

    int   n_checks = 0;
    int   n_errors = 0;

    int   m_mode  = M_IDLE;
    int   m_sec   = 0;
    int   m_left  = 0;
    bit   m_armed = 1'b0;
    bit   m_arrive = 1'b0;
    logic [5:0] m_prev = '1;

    always #5 clk = ~clk;

    track_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .sensor        (sensor),
        .start         (start),
        .clear         (clear),
        .dwell_time    (dwell_time),
        .timeout       (timeout),
        .section       (section),
        .present_state (present_state),
        .motor_en      (motor_en),
        .fault         (fault),
        .arrive        (arrive)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_ps();
        case (m_mode)
            M_IDLE:  return 0;
            M_DWELL: return 1 + m_sec;
            M_MOVE:  return 8 + m_sec;
            default: return 15;
        endcase
    endfunction

    // Applies one clock edge's worth of the sequencing rules to the model.
    task automatic model_step();
        int want;
        bit hit;
        bit other;
        if (!rst_n) begin
            m_mode = M_IDLE; m_sec = 0; m_left = 0; m_armed = 1'b0;
            m_arrive = 1'b0; m_prev = '1;
            return;
        end
        m_arrive = 1'b0;
        want  = (m_sec + 1) % N;
        hit   = 1'b0;
        other = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sensor[k] && !m_prev[k]) begin
                if (k == want) hit = 1'b1;
                else other = 1'b1;
            end
        end
        case (m_mode)
            M_IDLE: begin
                if (start && sensor[0]) begin
                    m_mode = M_DWELL; m_sec = 0; m_left = int'(dwell_time);
                end
            end
            M_DWELL: begin
                if (m_left == 0) begin
                    m_mode  = M_MOVE;
                    m_left  = WD ? int'(timeout) : 0;
                    m_armed = WD && (timeout != 0);
                end else if (tick) begin
                    m_left--;
                end
            end
            M_MOVE: begin
                if (other) m_mode = M_FAULT;
                else if (hit) begin
                    m_sec = want; m_arrive = 1'b1; m_left = int'(dwell_time); m_mode = M_DWELL;
                end else if (m_armed && m_left == 0) m_mode = M_FAULT;
                else if (tick && m_left > 0) m_left--;
            end
            default: begin
                if (clear) begin
                    m_mode = M_IDLE; m_sec = 0;
                end
            end
        endcase
        m_prev = sensor;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("section", 32'(section), 32'(m_sec));
        chk("present_state", 32'(present_state), 32'(exp_ps()));
        chk("motor_en", 32'(motor_en), 32'(m_mode == M_MOVE));
        chk("fault", 32'(fault), 32'(m_mode == M_FAULT));
        chk("arrive", 32'(arrive), 32'(m_arrive));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; tick = 1'b0; sensor = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic raise(input int k);
        sensor = 6'(1 << k);
        cycle();
    endtask

    task automatic to_move(input int dw, input int to);
        int guard;
        sensor = 6'b000001; start = 1'b1; dwell_time = 15'(dw); timeout = 19'(to); tick = 1'b1;
        cycle();
        start = 1'b0;
        guard = 0;
        while (m_mode != M_MOVE && guard < 100) begin
            cycle();
            guard++;
        end
        chk("to_move_reached", 32'(m_mode == M_MOVE), 32'd1);
    endtask

    initial begin
        int r;
        int want;
        int other;
        rst_n = 1'b0; tick = 1'b0; sensor = '0; start = 1'b0; clear = 1'b0;
        dwell_time = '0; timeout = '0;

        do_reset();
        chk("reset_ps", 32'(present_state), 32'h0);
        chk("reset_motor", 32'(motor_en), 32'h0);

        // start with dwell 3: DWELL for 3 ticks plus one cycle
        sensor = 6'b000001; start = 1'b1; dwell_time = 15'd3; timeout = '0; tick = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_ps", 32'(present_state), 32'h1);
        repeat (3) cycle();
        chk("dwell_hold_ps", 32'(present_state), 32'h1);
        cycle();
        chk("move_ps", 32'(present_state), 32'h8);
        chk("move_motor", 32'(motor_en), 32'h1);

        // walk the loop with zero dwell, including the 5 -> 0 wrap
        dwell_time = '0;
        for (int k = 1; k < N; k++) begin
            raise(k);
            chk("walk_arrive", 32'(arrive), 32'h1);
            chk("walk_dwell_ps", 32'(present_state), 32'(1 + k));
            cycle();
            chk("walk_move_ps", 32'(present_state), 32'(8 + k));
        end
        raise(0);
        chk("wrap_arrive", 32'(arrive), 32'h1);
        chk("wrap_section", 32'(section), 32'h0);
        chk("wrap_ps", 32'(present_state), 32'h1);
        cycle();

        // out-of-order edge from section 1, then clear
        raise(1);
        cycle();
        raise(3);
        chk("ooo_ps", 32'(present_state), 32'hF);
        chk("ooo_motor", 32'(motor_en), 32'h0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clear_ps", 32'(present_state), 32'h0);

        // watchdog with timeout 5
        to_move(0, 5);
        repeat (5) cycle();
        chk("wd5_before", 32'(fault), 32'h0);
        cycle();
        chk("wd5_fire", 32'(fault), 32'(WD));
        do_reset();

        // timeout 0 never arms
        to_move(0, 0);
        repeat (1000) cycle();
        chk("wd0_still_move", 32'(present_state), 32'h8);
        do_reset();

        // expected edge coincident with expiry wins
        to_move(0, 3);
        repeat (3) cycle();
        sensor = 6'b000010;
        cycle();
        chk("coinc_ps", 32'(present_state), 32'h2);
        chk("coinc_arrive", 32'(arrive), 32'h1);
        cycle();

        // expected plus foreign edge faults
        sensor = 6'b010100;
        cycle();
        chk("dual_edge_ps", 32'(present_state), 32'hF);

        // reset during MOVE
        do_reset();
        to_move(1, 0);
        rst_n = 1'b0;
        cycle();
        chk("rst_move_motor", 32'(motor_en), 32'h0);
        chk("rst_move_ps", 32'(present_state), 32'h0);
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r          = int'($urandom_range(0, 99));
            tick       = ($urandom_range(0, 99) < 60);
            start      = ($urandom_range(0, 99) < 30);
            clear      = ($urandom_range(0, 99) < 20);
            rst_n      = ($urandom_range(0, 299) != 0);
            dwell_time = 15'($urandom_range(0, 4));
            timeout    = ($urandom_range(0, 3) == 0) ? 19'd0 : 19'($urandom_range(1, 10));
            if (m_mode == M_MOVE) begin
                want  = (m_sec + 1) % N;
                other = (want + int'($urandom_range(1, N - 1))) % N;
                if (r < 12)      sensor = 6'(1 << want);
                else if (r < 15) sensor = 6'(1 << other);
                else if (r < 17) sensor = 6'((1 << want) | (1 << other));
                else if (r < 25) sensor = '0;
            end else if (m_mode == M_IDLE) begin
                if (r < 40)      sensor = 6'b000001;
                else if (r < 50) sensor = 6'($urandom_range(0, 63));
            end else if (r < 10) begin
                sensor = 6'($urandom_range(0, 63));
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/track_sequencer.md
# track_sequencer

Sequencing controller for the train loop. It takes the six synchronized track sensors and advances the train through sections 0..5 of the loop. At each station it holds the train for a programmed dwell time, then releases the motor and waits for the next expected sensor. Its `present_state` code drives the seven-segment state display, and its dwell and watchdog values come from the parameter/selector datapath.

## Interface
Parameters:
- `N_SEC`, 6: number of track sections/sensors; sections wrap `N_SEC-1 -> 0`.
- `DWELL_W`, 15: width of `dwell_time`.
- `TOUT_W`, 19: width of `timeout`.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tick`  in  1  one-cycle time-base strobe; all timing counts in ticks.
- `sensor`  in  `N_SEC`  synchronized sensor levels; bit k = train at section k.
- `start`  in  1  leave IDLE; sampled only in IDLE.
- `clear`  in  1  leave FAULT; sampled only in FAULT.
- `dwell_time`  in  `DWELL_W`  station hold in ticks; sampled on entry to DWELL.
- `timeout`  in  `TOUT_W`  watchdog in ticks; sampled on entry to MOVE; 0 = watchdog off.
- `section`  out  3  current section index.
- `present_state`  out  4  display code.
- `motor_en`  out  1  high only in MOVE.
- `fault`  out  1  high only in FAULT.
- `arrive`  out  1  one-cycle pulse when an expected sensor edge is accepted.

## Operation
- Edge detect: `sensor_q` is registered every cycle; `rise = sensor & ~sensor_q`. `sensor_q` resets to all-ones, so no edge is reported in the cycle after reset.
- Expected sensor `nxt = (section == N_SEC-1) ? 0 : section+1`.
- IDLE: if `start & sensor[0]`, then `section <= 0`, load counter with `dwell_time`, go to DWELL. `start` without `sensor[0]` is ignored.
- DWELL: on each `tick` with counter != 0, decrement. When counter == 0 (checked every cycle), load counter with `timeout` and go to MOVE.
- MOVE, evaluated in priority order:
  - `rise` on any bit other than `nxt`: go to FAULT. This also applies when it coincides with the `nxt` edge.
  - `rise[nxt]`: `section <= nxt`, pulse `arrive`, load `dwell_time`, go to DWELL.
  - Watchdog expiry: counter == 0 with the watchdog armed, go to FAULT.
  - Otherwise decrement on `tick`.
- FAULT: `motor_en` = 0 and `section` holds. `clear` returns to IDLE with `section <= 0`.
- Out-of-order sensor edges in IDLE and DWELL are ignored.
- `present_state` codes: IDLE 4'h0; DWELL at k is 4'h1+k (1..6); MOVE from k is 4'h8+k (8..D); FAULT 4'hF.

## Timing
- All outputs are registered and update on the same `clk` edge as the state.
- Reset values: state IDLE, `section` 0, `present_state` 4'h0, `motor_en` 0, `fault` 0, `arrive` 0, counter 0.
- Reset mid-operation: state returns to IDLE on the next edge with `rst_n` low, and the motor drops in that same cycle.
- `start` to DWELL: 1 cycle.
- DWELL lasts `dwell_time` ticks plus 1 cycle. With `dwell_time` = 0, DWELL lasts exactly 1 cycle.
- Sensor edge to `arrive`/DWELL: the sensor rises at cycle n, `rise` is combinational at n, and the state and `arrive` update at n+1.
- The watchdog fires on the cycle where the counter is 0, after `timeout` ticks in MOVE. With `timeout` = 0 the watchdog is never armed.
- An expected edge in the same cycle as watchdog expiry wins (transition to DWELL).

## Configuration
- `WATCHDOG_EN` defined: MOVE timeout behaves as described above.
- `WATCHDOG_EN` undefined: the `timeout` port remains but is ignored. The counter is not loaded in MOVE, MOVE waits indefinitely, and FAULT is reached only through out-of-order sensor edges.

## Structure
- Package `track_pkg` holds:
  - the state enum (IDLE, DWELL, MOVE, FAULT);
  - the `present_state` code constants (`PS_IDLE`, `PS_DWELL_BASE`, `PS_MOVE_BASE`, `PS_FAULT`);
  - the default `N_SEC`.
- One sub-module, `tick_downcounter`: width max(`DWELL_W`, `TOUT_W`), with `load`/`value`/`tick` inputs and a `zero` flag. It is shared by dwell and watchdog because they are never active at the same time.

## Test plan
- Reset, then `start` with `sensor`=6'b000001 and `dwell_time`=3 -> DWELL with `present_state`=1. After 3 ticks plus 1 cycle: MOVE, `present_state`=8, `motor_en`=1.
- In MOVE from section 5, raise `sensor[0]` -> `arrive` pulses, `section`=0, `present_state`=1. Confirms wrap-around.
- In MOVE from section 1, raise `sensor[3]` -> FAULT, `present_state`=F, `motor_en`=0. Then `clear` -> IDLE with `present_state`=0.
- With `WATCHDOG_EN` and `timeout`=5, no sensor edge -> FAULT exactly on the 5th-tick zero cycle. With `timeout`=0 the bench stays in MOVE for 1000 ticks.
- Expected edge coincident with watchdog expiry -> DWELL, not FAULT. Expected edge and a foreign edge in the same cycle -> FAULT.
- `dwell_time`=0 -> DWELL lasts 1 cycle. `rst_n` low during MOVE -> next edge gives IDLE with `motor_en`=0.
